// File: rtl/ppu_pkg.sv
// Shared PPU definitions: control-word bit map, source-operand encodings,
// forwarding-select codes and the destination-register helper.
package ppu_pkg;

    localparam int unsigned REG_W = 5;

    // Control word bit positions
    localparam int unsigned CTRL_COND     = 21;
    localparam int unsigned CTRL_R31      = 20;
    localparam int unsigned CTRL_UJUMP    = 19;
    localparam int unsigned CTRL_DEST     = 18;
    localparam int unsigned CTRL_SRC_HI   = 17;
    localparam int unsigned CTRL_SRC_LO   = 15;
    localparam int unsigned CTRL_ALU_HI   = 14;
    localparam int unsigned CTRL_ALU_LO   = 11;
    localparam int unsigned CTRL_LOAD     = 10;
    localparam int unsigned CTRL_RF_EN    = 9;
    localparam int unsigned CTRL_B_INSTR  = 8;
    localparam int unsigned CTRL_TA_INSTR = 7;
    localparam int unsigned CTRL_MSIZE_HI = 6;
    localparam int unsigned CTRL_MSIZE_LO = 5;
    localparam int unsigned CTRL_MEM_RW   = 4;
    localparam int unsigned CTRL_MEM_SE   = 3;
    localparam int unsigned CTRL_HI_EN    = 2;
    localparam int unsigned CTRL_LO_EN    = 1;
    localparam int unsigned CTRL_MEM_EN   = 0;

    // Source-operand encodings; bit 2 set means the instruction writes rt
    localparam logic [2:0] SRC_OP_RR     = 3'b000;
    localparam logic [2:0] SRC_OP_SHIFT  = 3'b001;
    localparam logic [2:0] SRC_OP_IMM_SE = 3'b100;
    localparam logic [2:0] SRC_OP_LUI    = 3'b101;
    localparam logic [2:0] SRC_OP_IMM_ZE = 3'b110;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_W-1:0] REG_RA   = 5'd31;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    function automatic logic [REG_W-1:0] dest_reg(input logic r31, input logic src_hi,
                                                  input logic [REG_W-1:0] rt,
                                                  input logic [REG_W-1:0] rd);
        if (r31)
            return REG_RA;
        else if (src_hi)
            return rt;
        else
            return rd;
    endfunction

endpackage

// File: rtl/ppu_hazard_fwd.sv
// Combinational hazard detection and per-operand forwarding select for ID/EX.
// FWD_EN defined: forward EX/MEM/WB and stall only on load-use; undefined: stall until retired.
module ppu_hazard_fwd
    import ppu_pkg::*;
(
    input  logic [2:0]       id_src_op,
    input  logic             id_r31,
    input  logic             id_ujump,
    input  logic             id_mem_en,
    input  logic             id_load,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_load,
    input  logic             ex_rf_en,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             mem_rf_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             wb_rf_en,
    input  logic [REG_W-1:0] wb_dest,
    output logic             hazard_c,
    output logic [1:0]       sel_a_c,
    output logic [1:0]       sel_b_c
);

    logic rs_live, rt_live;
    logic ex_wr, mem_wr, wb_wr;
    logic ex_hit, mem_hit, wb_hit, ld_use;

    always_comb begin
        rs_live = !(id_ujump && id_r31) && (id_src_op != SRC_OP_LUI) && (id_rs != REG_ZERO);
        rt_live = ((id_src_op == SRC_OP_RR) || (id_mem_en && !id_load)) && (id_rt != REG_ZERO);
        ex_wr   = ex_rf_en && (ex_dest != REG_ZERO);
        mem_wr  = mem_rf_en && (mem_dest != REG_ZERO);
        wb_wr   = wb_rf_en && (wb_dest != REG_ZERO);

        ex_hit  = ex_wr && ((rs_live && ex_dest == id_rs) || (rt_live && ex_dest == id_rt));
        mem_hit = mem_wr && ((rs_live && mem_dest == id_rs) || (rt_live && mem_dest == id_rt));
        wb_hit  = wb_wr && ((rs_live && wb_dest == id_rs) || (rt_live && wb_dest == id_rt));
        ld_use  = ex_hit && ex_load;

        sel_a_c  = FWD_RF;
        sel_b_c  = FWD_RF;
`ifdef FWD_EN
        hazard_c = ld_use;
        // Youngest producer wins; a load in EX is never a source
        if (rs_live) begin
            if (ex_wr && !ex_load && ex_dest == id_rs)  sel_a_c = FWD_EX;
            else if (mem_wr && mem_dest == id_rs)       sel_a_c = FWD_MEM;
            else if (wb_wr && wb_dest == id_rs)         sel_a_c = FWD_WB;
        end
        if (rt_live) begin
            if (ex_wr && !ex_load && ex_dest == id_rt)  sel_b_c = FWD_EX;
            else if (mem_wr && mem_dest == id_rt)       sel_b_c = FWD_MEM;
            else if (wb_wr && wb_dest == id_rt)         sel_b_c = FWD_WB;
        end
`else
        hazard_c = ld_use || ex_hit || mem_hit || wb_hit;
`endif
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard stall, operand forwarding and bubble counting.
// Forwarding is enabled by defining FWD_EN; otherwise dependent instructions stall.
module id_ex_stage
    import ppu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 22,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic [DATA_W-1:0] id_rt_val,
    input  logic [15:0]       id_imm16,
    input  logic [31:0]       id_pc,
    input  logic              flush,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_rf_en,
    input  logic [4:0]        mem_dest,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_rf_en,
    input  logic [4:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_result,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [15:0]       ex_imm,
    output logic [31:0]       ex_pc,
    output logic [4:0]        ex_dest,
    output logic              stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [DATA_W-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
    logic [15:0]       ex_imm_q, ex_imm_d;
    logic [31:0]       ex_pc_q, ex_pc_d;
    logic [4:0]        ex_dest_q, ex_dest_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic       hazard_c, bubble;
    logic [1:0] sel_a_c, sel_b_c;
    logic [DATA_W-1:0] opa, opb;

    ppu_hazard_fwd u_hazard (
        .id_src_op (id_ctrl[CTRL_SRC_HI:CTRL_SRC_LO]),
        .id_r31    (id_ctrl[CTRL_R31]),
        .id_ujump  (id_ctrl[CTRL_UJUMP]),
        .id_mem_en (id_ctrl[CTRL_MEM_EN]),
        .id_load   (id_ctrl[CTRL_LOAD]),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .ex_load   (ex_ctrl_q[CTRL_LOAD]),
        .ex_rf_en  (ex_ctrl_q[CTRL_RF_EN]),
        .ex_dest   (ex_dest_q),
        .mem_rf_en (mem_rf_en),
        .mem_dest  (mem_dest),
        .wb_rf_en  (wb_rf_en),
        .wb_dest   (wb_dest),
        .hazard_c  (hazard_c),
        .sel_a_c   (sel_a_c),
        .sel_b_c   (sel_b_c)
    );

    // Next-state: operand muxes, bubble insertion, saturating bubble count
    always_comb begin
        stall  = hazard_c && !flush;
        bubble = stall || flush;

        case (sel_a_c)
            FWD_EX:  opa = ex_result;
            FWD_MEM: opa = mem_result;
            FWD_WB:  opa = wb_result;
            default: opa = id_rs_val;
        endcase
        case (sel_b_c)
            FWD_EX:  opb = ex_result;
            FWD_MEM: opb = mem_result;
            FWD_WB:  opb = wb_result;
            default: opb = id_rt_val;
        endcase

        ex_ctrl_d = id_ctrl;
        ex_a_d    = opa;
        ex_b_d    = opb;
        ex_imm_d  = id_imm16;
        ex_pc_d   = id_pc;
        ex_dest_d = dest_reg(id_ctrl[CTRL_R31], id_ctrl[CTRL_SRC_HI], id_rt, id_rd);
        if (bubble) begin
            ex_ctrl_d = '0;
            ex_a_d    = '0;
            ex_b_d    = '0;
            ex_imm_d  = '0;
            ex_pc_d   = '0;
            ex_dest_d = '0;
        end

        bubble_cnt_d = bubble_cnt_q;
        if (bubble && (bubble_cnt_q != {CNT_W{1'b1}}))
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ctrl_q    <= '0;
            ex_a_q       <= '0;
            ex_b_q       <= '0;
            ex_imm_q     <= '0;
            ex_pc_q      <= '0;
            ex_dest_q    <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_ctrl_q    <= ex_ctrl_d;
            ex_a_q       <= ex_a_d;
            ex_b_q       <= ex_b_d;
            ex_imm_q     <= ex_imm_d;
            ex_pc_q      <= ex_pc_d;
            ex_dest_q    <= ex_dest_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_ctrl    = ex_ctrl_q;
    assign ex_a       = ex_a_q;
    assign ex_b       = ex_b_q;
    assign ex_imm     = ex_imm_q;
    assign ex_pc      = ex_pc_q;
    assign ex_dest    = ex_dest_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expectations follow the build's FWD_EN setting.
module tb_id_ex_stage;

`ifdef FWD_EN
    localparam bit F = 1'b1;
`else
    localparam bit F = 1'b0;
`endif

    localparam logic [21:0] ADDIU = 22'h020A00;
    localparam logic [21:0] SUBU  = 22'h001200;
    localparam logic [21:0] LBU   = 22'h020E01;
    localparam logic [21:0] SW    = 22'h020871;
    localparam logic [21:0] JAL   = 22'h3B0200;
    localparam logic [21:0] LUI   = 22'h028200;

    logic        clk, reset, flush;
    logic [21:0] id_ctrl;
    logic [4:0]  id_rs, id_rt, id_rd, mem_dest, wb_dest;
    logic [31:0] id_rs_val, id_rt_val, id_pc, ex_result, mem_result, wb_result;
    logic [15:0] id_imm16;
    logic        mem_rf_en, wb_rf_en;
    logic [21:0] ex_ctrl;
    logic [31:0] ex_a, ex_b, ex_pc;
    logic [15:0] ex_imm, bubble_cnt;
    logic [4:0]  ex_dest;
    logic        stall;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [21:0] ctrl;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_val, rt_val;
        logic [15:0] imm;
        logic [31:0] pc;
        logic        fl;
        logic [31:0] ex_res;
        logic        m_en;
        logic [4:0]  m_dest;
        logic [31:0] m_res;
        logic        w_en;
        logic [4:0]  w_dest;
        logic [31:0] w_res;
        logic        e_stall;
        logic        e_bub;
        logic [31:0] e_a, e_b;
        logic [4:0]  e_dest;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm16(id_imm16),
        .id_pc(id_pc), .flush(flush), .ex_result(ex_result), .mem_rf_en(mem_rf_en),
        .mem_dest(mem_dest), .mem_result(mem_result), .wb_rf_en(wb_rf_en), .wb_dest(wb_dest),
        .wb_result(wb_result), .ex_ctrl(ex_ctrl), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_pc(ex_pc), .ex_dest(ex_dest), .stall(stall), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_ctrl = v.ctrl;   id_rs = v.rs;   id_rt = v.rt;   id_rd = v.rd;
        id_rs_val = v.rs_val; id_rt_val = v.rt_val; id_imm16 = v.imm; id_pc = v.pc;
        flush = v.fl;       ex_result = v.ex_res;
        mem_rf_en = v.m_en; mem_dest = v.m_dest; mem_result = v.m_res;
        wb_rf_en = v.w_en;  wb_dest = v.w_dest;  wb_result = v.w_res;
    endtask

    initial begin
        vec_t v;
        // Reset with an ADDIU waiting in ID
        v = '{ADDIU, 5'd2, 5'd4, 5'd9, 32'h1111, 32'h2222, 16'h00FF, 32'h3C, 1'b0,
              32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 16'd0};
        reset = 1'b1;
        drive(v);
        repeat (2) @(posedge clk);
        #1;
        chk("rst ctrl", 32'(ex_ctrl), 32'h0);
        chk("rst a", ex_a, 32'h0);
        chk("rst b", ex_b, 32'h0);
        chk("rst imm", 32'(ex_imm), 32'h0);
        chk("rst pc", ex_pc, 32'h0);
        chk("rst dest", 32'(ex_dest), 32'h0);
        chk("rst stall", 32'(stall), 32'h0);
        chk("rst cnt", 32'(bubble_cnt), 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post-rst ctrl", 32'(ex_ctrl), 32'(ADDIU));
        chk("post-rst dest", 32'(ex_dest), 32'd4);
        chk("post-rst a", ex_a, 32'h1111);
        chk("post-rst b", ex_b, 32'h2222);
        chk("post-rst imm", 32'(ex_imm), 32'hFF);
        chk("post-rst pc", ex_pc, 32'h3C);

        // ctrl rs rt rd rs_val rt_val imm pc flush | ex_res mem(en,dest,res) wb(en,dest,res) | stall bub a b dest cnt
        tbl.push_back('{LBU,  5'd1, 5'd5, 5'd0, 32'h100, 32'h55, 16'h4, 32'h40, 1'b0,
                        32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                        1'b0, 1'b0, 32'h100, 32'h55, 5'd5, 16'd0});
        tbl.push_back('{SUBU, 5'd5, 5'd6, 5'd8, 32'h11, 32'h22, 16'h1234, 32'h44, 1'b0,
                        32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                        1'b1, 1'b1, 32'h11, 32'h22, 5'd8, 16'd1});
        tbl.push_back('{SUBU, 5'd5, 5'd6, 5'd8, 32'h11, 32'h22, 16'h1234, 32'h44, 1'b0,
                        32'h0, 1'b1, 5'd5, 32'hA5, 1'b0, 5'd0, 32'h0,
                        !F, !F, 32'hA5, 32'h22, 5'd8, F ? 16'd1 : 16'd2});
        tbl.push_back('{SUBU, 5'd5, 5'd6, 5'd8, 32'h11, 32'h22, 16'h1234, 32'h44, 1'b0,
                        32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hA5,
                        !F, !F, 32'hA5, 32'h22, 5'd8, F ? 16'd1 : 16'd3});
        tbl.push_back('{SUBU, 5'd5, 5'd6, 5'd8, 32'h11, 32'h22, 16'h1234, 32'h44, 1'b0,
                        32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                        1'b0, 1'b0, 32'h11, 32'h22, 5'd8, F ? 16'd1 : 16'd3});
        tbl.push_back('{ADDIU, 5'd0, 5'd3, 5'd0, 32'h0, 32'h0, 16'h10, 32'h50, 1'b0,
                        32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                        1'b0, 1'b0, 32'h0, 32'h0, 5'd3, F ? 16'd1 : 16'd3});
        tbl.push_back('{SUBU, 5'd3, 5'd3, 5'd10, 32'h3333, 32'h4444, 16'h0, 32'h54, 1'b0,
                        32'h10, 1'b1, 5'd3, 32'h20, 1'b1, 5'd3, 32'h30,
                        !F, !F, 32'h10, 32'h10, 5'd10, F ? 16'd1 : 16'd4});
        tbl.push_back('{JAL,  5'd3, 5'd3, 5'd0, 32'h3333, 32'h4444, 16'h0, 32'h60, 1'b0,
                        32'h10, 1'b1, 5'd3, 32'h20, 1'b1, 5'd3, 32'h30,
                        1'b0, 1'b0, 32'h3333, 32'h4444, 5'd31, F ? 16'd1 : 16'd4});
        tbl.push_back('{SUBU, 5'd0, 5'd0, 5'd12, 32'h7, 32'h9, 16'h0, 32'h64, 1'b0,
                        32'hDEAD, 1'b1, 5'd0, 32'hBAD, 1'b1, 5'd0, 32'hBEE,
                        1'b0, 1'b0, 32'h7, 32'h9, 5'd12, F ? 16'd1 : 16'd4});
        tbl.push_back('{SUBU, 5'd1, 5'd2, 5'd0, 32'h1, 32'h2, 16'h0, 32'h68, 1'b0,
                        32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                        1'b0, 1'b0, 32'h1, 32'h2, 5'd0, F ? 16'd1 : 16'd4});
        tbl.push_back('{SUBU, 5'd0, 5'd0, 5'd13, 32'h7, 32'h9, 16'h0, 32'h6C, 1'b0,
                        32'hDEAD, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                        1'b0, 1'b0, 32'h7, 32'h9, 5'd13, F ? 16'd1 : 16'd4});
        tbl.push_back('{LBU,  5'd1, 5'd20, 5'd0, 32'h100, 32'h0, 16'h8, 32'h70, 1'b0,
                        32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                        1'b0, 1'b0, 32'h100, 32'h0, 5'd20, F ? 16'd1 : 16'd4});
        tbl.push_back('{SW,   5'd20, 5'd21, 5'd0, 32'h5, 32'h6, 16'hC, 32'h74, 1'b1,
                        32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                        1'b0, 1'b1, 32'h5, 32'h6, 5'd21, F ? 16'd2 : 16'd5});
        tbl.push_back('{SW,   5'd20, 5'd20, 5'd0, 32'h5, 32'h6, 16'hC, 32'h78, 1'b0,
                        32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                        1'b0, 1'b0, 32'h5, 32'h6, 5'd20, F ? 16'd2 : 16'd5});
        tbl.push_back('{SW,   5'd1, 5'd22, 5'd0, 32'h1, 32'h2, 16'h0, 32'h7C, 1'b0,
                        32'h0, 1'b1, 5'd22, 32'h222, 1'b0, 5'd0, 32'h0,
                        !F, !F, 32'h1, 32'h222, 5'd22, F ? 16'd2 : 16'd6});
        tbl.push_back('{LUI,  5'd22, 5'd23, 5'd0, 32'h11, 32'h12, 16'h1, 32'h80, 1'b0,
                        32'h0, 1'b1, 5'd22, 32'h222, 1'b0, 5'd0, 32'h0,
                        1'b0, 1'b0, 32'h11, 32'h12, 5'd23, F ? 16'd2 : 16'd6});
        tbl.push_back('{LBU,  5'd9, 5'd22, 5'd0, 32'h9, 32'h44, 16'h2, 32'h84, 1'b0,
                        32'h0, 1'b1, 5'd22, 32'h222, 1'b0, 5'd0, 32'h0,
                        1'b0, 1'b0, 32'h9, 32'h44, 5'd22, F ? 16'd2 : 16'd6});
        tbl.push_back('{SUBU, 5'd0, 5'd7, 5'd9, 32'h0, 32'h77, 16'h0, 32'h88, 1'b0,
                        32'h0, 1'b1, 5'd7, 32'h700, 1'b0, 5'd0, 32'h0,
                        !F, !F, 32'h0, 32'h700, 5'd9, F ? 16'd2 : 16'd7});
        tbl.push_back('{SUBU, 5'd0, 5'd7, 5'd9, 32'h0, 32'h77, 16'h0, 32'h88, 1'b0,
                        32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h700,
                        !F, !F, 32'h0, 32'h700, 5'd9, F ? 16'd2 : 16'd8});
        tbl.push_back('{SUBU, 5'd0, 5'd7, 5'd9, 32'h0, 32'h77, 16'h0, 32'h88, 1'b0,
                        32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                        1'b0, 1'b0, 32'h0, 32'h77, 5'd9, F ? 16'd2 : 16'd8});

        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("r%0d stall", i), 32'(stall), 32'(tbl[i].e_stall));
            @(posedge clk);
            #1;
            chk($sformatf("r%0d ctrl", i), 32'(ex_ctrl), tbl[i].e_bub ? 32'h0 : 32'(tbl[i].ctrl));
            chk($sformatf("r%0d a", i), ex_a, tbl[i].e_bub ? 32'h0 : tbl[i].e_a);
            chk($sformatf("r%0d b", i), ex_b, tbl[i].e_bub ? 32'h0 : tbl[i].e_b);
            chk($sformatf("r%0d dest", i), 32'(ex_dest), tbl[i].e_bub ? 32'h0 : 32'(tbl[i].e_dest));
            chk($sformatf("r%0d imm", i), 32'(ex_imm), tbl[i].e_bub ? 32'h0 : 32'(tbl[i].imm));
            chk($sformatf("r%0d pc", i), ex_pc, tbl[i].e_bub ? 32'h0 : tbl[i].pc);
            chk($sformatf("r%0d cnt", i), 32'(bubble_cnt), 32'(tbl[i].e_cnt));
        end

        // Reset arriving while a load-use stall is active
        v = '{LBU, 5'd1, 5'd5, 5'd0, 32'h1, 32'h2, 16'h0, 32'h90, 1'b0,
              32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 16'd0};
        drive(v);
        @(posedge clk);
        #1;
        v.ctrl = SUBU; v.rs = 5'd5; v.rt = 5'd6; v.rd = 5'd8;
        drive(v);
        reset = 1'b1;
        #1;
        chk("midrst stall before", 32'(stall), 32'h1);
        @(posedge clk);
        #1;
        chk("midrst ctrl", 32'(ex_ctrl), 32'h0);
        chk("midrst stall after", 32'(stall), 32'h0);
        chk("midrst cnt", 32'(bubble_cnt), 32'h0);

        // Saturation of the bubble counter via repeated flushes
        reset = 1'b0;
        flush = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat cnt fffe", 32'(bubble_cnt), 32'hFFFE);
        chk("sat stall", 32'(stall), 32'h0);
        @(posedge clk);
        #1;
        chk("sat cnt ffff", 32'(bubble_cnt), 32'hFFFF);
        @(posedge clk);
        #1;
        chk("sat cnt hold", 32'(bubble_cnt), 32'hFFFF);
        chk("sat ctrl", 32'(ex_ctrl), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
